// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Purpose: FSM state encoding, memory size codes and default requester count.
// Ports: none (package).
// Optional feature macro used by the arbiter: DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Size codes; the memory interprets them, the arbiter only forwards them.
   localparam logic [2:0] MASK_LB  = 3'b000;
   localparam logic [2:0] MASK_LH  = 3'b001;
   localparam logic [2:0] MASK_LW  = 3'b010;
   localparam logic [2:0] MASK_LBU = 3'b100;
   localparam logic [2:0] MASK_LHU = 3'b101;

   localparam int N_REQ_DEFAULT = 2;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - combinational round-robin winner select
// Purpose: pick the first requester strictly after ptr_i, wrapping around.
// Ports:
//   req_i     in  N_REQ  request vector
//   ptr_i     in  IW     index of the most recently served requester
//   onehot_o  out N_REQ  one-hot winner (0 when no request)
//   idx_o     out IW     winner index
//   any_o     out 1      at least one request present
module rr_picker #(
   parameter int N_REQ = 2,
   parameter int IW    = 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [IW-1:0]    idx_o,
   output logic             any_o
);

   // Two ascending passes: indices above the pointer first, then the wrap
   // region up to and including the pointer. Keeps every select constant.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_o && req_i[i] && (IW'(i) > ptr_i)) begin
            any_o       = 1'b1;
            idx_o       = IW'(i);
            onehot_o[i] = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_o && req_i[i] && (IW'(i) <= ptr_i)) begin
            any_o       = 1'b1;
            idx_o       = IW'(i);
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port
// Purpose: latch one accepted request, drive memory for one cycle, return result.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req/req_we            per-requester request and store flag
//   req_addr/wdata/mask   packed per-requester payload (requester i at [i*W +: W])
//   gnt                   one-hot, high during ACCESS for the winner
//   done, rdata           one-cycle completion pulse and load result in RESP
//   mem_addr/wdata/mask   memory payload, driven only in ACCESS
//   mem_wr_en/mem_rd_en   memory strobes, driven only in ACCESS
//   mem_rdata             combinational read data from memory
//   stat_grants/stat_wait per-requester saturating counters (DMEM_ARB_STATS_EN only)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   req_we,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   input  logic [N_REQ*3-1:0] req_mask,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic [2:0]         mem_mask,
   output logic               mem_wr_en,
   output logic               mem_rd_en,
   input  logic [DW-1:0]      mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [N_REQ*32-1:0] stat_grants,
   output logic [N_REQ*32-1:0] stat_wait
`endif
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [2:0]    mask_q, mask_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;

   rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   // Async reset also drops the ACCESS strobes immediately, which is what
   // aborts a store that has not reached its negedge commit yet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= IW'(N_REQ - 1);
         idx_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mask_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mask_q   <= mask_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d  = ACCESS;
               rr_ptr_d = pick_idx;
               idx_d    = pick_idx;
               for (int i = 0; i < N_REQ; i++) begin
                  if (pick_onehot[i]) begin
                     we_d    = req_we[i];
                     addr_d  = req_addr[i*AW +: AW];
                     wdata_d = req_wdata[i*DW +: DW];
                     mask_d  = req_mask[i*3 +: 3];
                  end
               end
            end
         end
         ACCESS: begin
            // Stores return zero so RESP can forward rdata_q unconditionally.
            rdata_d = we_q ? '0 : mem_rdata;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt       = '0;
      done      = '0;
      rdata     = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mask  = '0;
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
      if (state_q == ACCESS) begin
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
         mem_mask  = mask_q;
         mem_wr_en = we_q;
         mem_rd_en = !we_q;
      end
      if (state_q == RESP) begin
         rdata = rdata_q;
      end
      for (int i = 0; i < N_REQ; i++) begin
         gnt[i]  = (state_q == ACCESS) && (idx_q == IW'(i));
         done[i] = (state_q == RESP) && (idx_q == IW'(i));
      end
   end

`ifdef DMEM_ARB_STATS_EN
   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      logic [31:0] grants_q;
      logic [31:0] wait_q;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            grants_q <= '0;
            wait_q   <= '0;
         end else begin
            if (gnt[g] && (grants_q != 32'hFFFF_FFFF)) begin
               grants_q <= grants_q + 32'd1;
            end
            if (req[g] && !gnt[g] && !done[g] && (wait_q != 32'hFFFF_FFFF)) begin
               wait_q <= wait_q + 32'd1;
            end
         end
      end
      assign stat_grants[g*32 +: 32] = grants_q;
      assign stat_wait[g*32 +: 32]   = wait_q;
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*3-1:0]  req_mask;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic [DW-1:0]   rdata;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [2:0]      mem_mask;
   logic            mem_wr_en;
   logic            mem_rd_en;
   logic [DW-1:0]   mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [N*32-1:0] stat_grants;
   logic [N*32-1:0] stat_wait;
`endif

   int checks = 0;
   int passes = 0;

   logic [7:0] mem [0:255];

   dmem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_mask  (req_mask),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mask  (mem_mask),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_wait   (stat_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: combinational read with size/sign handling, negedge write.
   logic [7:0] ma, b0, b1, b2, b3;
   always_comb begin
      ma = mem_addr[7:0];
      b0 = mem[ma];
      b1 = mem[ma + 8'd1];
      b2 = mem[ma + 8'd2];
      b3 = mem[ma + 8'd3];
      case (mem_mask)
         3'b000:  mem_rdata = {{24{b0[7]}}, b0};
         3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
         3'b100:  mem_rdata = {24'h0, b0};
         3'b101:  mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = {b3, b2, b1, b0};
      endcase
   end

   always @(negedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr[7:0]] = mem_wdata[7:0];
         if (mem_mask != 3'b000) mem[mem_addr[7:0] + 8'd1] = mem_wdata[15:8];
         if (mem_mask == 3'b010) begin
            mem[mem_addr[7:0] + 8'd2] = mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3] = mem_wdata[31:24];
         end
      end
   end

   function automatic logic [31:0] mw(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   task automatic put_word(input int a, input logic [31:0] v);
      mem[a]   = v[7:0];
      mem[a+1] = v[15:8];
      mem[a+2] = v[23:16];
      mem[a+3] = v[31:24];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_payload(input int r, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] m);
      req_we[r]            = we;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      req_mask[r*3 +: 3]   = m;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Runs one request to completion; ok=0 if done never arrives.
   task automatic single_txn(input int r, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] m,
                             output bit ok, output logic [31:0] rd);
      ok = 1'b0;
      rd = '0;
      set_payload(r, we, a, d, m);
      req[r] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done[r]) begin
            ok = 1'b1;
            rd = rdata;
            break;
         end
      end
      req[r] = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_mask  = '0;
      #2;
      checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else passes++;
      checks++; if (done !== 2'b00) $display("FAIL reset_done: got %b want 00", done); else passes++;
      checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passes++;
      checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_wr_en, mem_rd_en}); else passes++;
      checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passes++;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single_load();
      put_word(32'h40, 32'hDEADBEEF);
      set_payload(0, 1'b0, 32'h40, 32'h0, 3'b010);
      req[0] = 1'b1;
      tick();
      checks++; if (gnt !== 2'b01) $display("FAIL t1_gnt: got %b want 01", gnt); else passes++;
      checks++; if ({mem_rd_en, mem_wr_en} !== 2'b10) $display("FAIL t1_strobes: got %b want 10", {mem_rd_en, mem_wr_en}); else passes++;
      req_addr[0 +: AW] = 32'h80;
      #1;
      checks++; if (mem_addr !== 32'h40) $display("FAIL t1_addr_held: got %h want 00000040", mem_addr); else passes++;
      tick();
      checks++; if (done !== 2'b01) $display("FAIL t1_done: got %b want 01", done); else passes++;
      checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL t1_rdata: got %h want deadbeef", rdata); else passes++;
      checks++; if (gnt !== 2'b00) $display("FAIL t1_gnt_off: got %b want 00", gnt); else passes++;
      req[0] = 1'b0;
      tick();
      checks++; if ({done, rdata} !== 34'h0) $display("FAIL t1_after: got done=%b rdata=%h want 0", done, rdata); else passes++;
      tick();
   endtask

   task automatic test_dual_store();
      int c0 = -1;
      int c1 = -1;
      logic [31:0] rd0 = 32'hX;
      apply_reset();
      set_payload(0, 1'b1, 32'h10, 32'h11112222, 3'b010);
      set_payload(1, 1'b1, 32'h20, 32'h33334444, 3'b010);
      req = 2'b11;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (done[0]) begin c0 = c; rd0 = rdata; req[0] = 1'b0; end
         if (done[1]) begin c1 = c; req[1] = 1'b0; end
         if (c0 >= 0 && c1 >= 0) break;
      end
      req = '0;
      tick();
      checks++; if (c0 !== 2) $display("FAIL t2_done0_cycle: got %0d want 2", c0); else passes++;
      checks++; if (c1 !== 5) $display("FAIL t2_done1_cycle: got %0d want 5", c1); else passes++;
      checks++; if (rd0 !== 32'h0) $display("FAIL t2_store_rdata: got %h want 0", rd0); else passes++;
      checks++; if (mw(32'h10) !== 32'h11112222) $display("FAIL t2_mem0: got %h want 11112222", mw(32'h10)); else passes++;
      checks++; if (mw(32'h20) !== 32'h33334444) $display("FAIL t2_mem1: got %h want 33334444", mw(32'h20)); else passes++;
   endtask

   task automatic test_round_robin();
      int n0 = 0;
      int n1 = 0;
      int order[$];
      bit onehot_ok = 1'b1;
      bit rd_ok = 1'b1;
      bit alt_ok = 1'b1;
      apply_reset();
      set_payload(0, 1'b0, 32'h40, 32'h0, 3'b010);
      set_payload(1, 1'b0, 32'h10, 32'h0, 3'b010);
      req = 2'b11;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (!$onehot0(gnt)) onehot_ok = 1'b0;
         if (gnt != 2'b00) order.push_back(gnt[1] ? 1 : 0);
         if (done[0]) begin
            n0++;
            if (rdata !== 32'hDEADBEEF) rd_ok = 1'b0;
            if (n0 == 3) req[0] = 1'b0;
         end
         if (done[1]) begin
            n1++;
            if (rdata !== 32'h11112222) rd_ok = 1'b0;
            if (n1 == 3) req[1] = 1'b0;
         end
         if (n0 == 3 && n1 == 3) break;
      end
      req = '0;
      tick();
      foreach (order[k]) if (order[k] != (k % 2)) alt_ok = 1'b0;
      checks++; if (n0 != 3 || n1 != 3) $display("FAIL t3_count: got %0d,%0d want 3,3", n0, n1); else passes++;
      checks++; if (order.size() != 6) $display("FAIL t3_grants: got %0d want 6", order.size()); else passes++;
      checks++; if (!alt_ok) $display("FAIL t3_alternate: got %p want 0,1,0,1,0,1", order); else passes++;
      checks++; if (!onehot_ok) $display("FAIL t3_onehot: got non-one-hot gnt want one-hot"); else passes++;
      checks++; if (!rd_ok) $display("FAIL t3_rdata: got wrong load data want deadbeef/11112222"); else passes++;
`ifdef DMEM_ARB_STATS_EN
      checks++; if (stat_grants[31:0] !== 32'd3) $display("FAIL t6_grants0: got %0d want 3", stat_grants[31:0]); else passes++;
      checks++; if (stat_grants[63:32] !== 32'd3) $display("FAIL t6_grants1: got %0d want 3", stat_grants[63:32]); else passes++;
      checks++; if (stat_wait[63:32] < 32'd3) $display("FAIL t6_wait1: got %0d want >=3", stat_wait[63:32]); else passes++;
`endif
   endtask

   task automatic test_byte_access();
      bit ok;
      logic [31:0] rd;
      single_txn(1, 1'b1, 32'h41, 32'h000000AB, 3'b000, ok, rd);
      checks++; if (!ok) $display("FAIL t4_sb_done: got timeout want done"); else passes++;
      single_txn(1, 1'b0, 32'h41, 32'h0, 3'b100, ok, rd);
      checks++; if (!ok || rd !== 32'h000000AB) $display("FAIL t4_lbu: got ok=%0d rdata=%h want 000000ab", ok, rd); else passes++;
      single_txn(1, 1'b1, 32'h41, 32'h00000080, 3'b000, ok, rd);
      single_txn(1, 1'b0, 32'h41, 32'h0, 3'b000, ok, rd);
      checks++; if (!ok || rd !== 32'hFFFFFF80) $display("FAIL t4_lb: got ok=%0d rdata=%h want ffffff80", ok, rd); else passes++;
      checks++; if (mw(32'h40) !== 32'hDEAD80EF) $display("FAIL t4_neighbours: got %h want dead80ef", mw(32'h40)); else passes++;
   endtask

   task automatic test_reset_abort();
      bit ok;
      bit saw_done = 1'b0;
      logic [31:0] rd;
      put_word(32'h60, 32'h12345678);
      set_payload(0, 1'b1, 32'h60, 32'hCAFEF00D, 3'b010);
      req[0] = 1'b1;
      tick();
      checks++; if ({gnt[0], mem_wr_en} !== 2'b11) $display("FAIL t5_access: got %b want 11", {gnt[0], mem_wr_en}); else passes++;
      #1;
      reset = 1'b1;
      #1;
      checks++; if ({gnt, mem_wr_en} !== 3'b000) $display("FAIL t5_abort: got %b want 000", {gnt, mem_wr_en}); else passes++;
      req[0] = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done != 2'b00) saw_done = 1'b1;
      end
      checks++; if (saw_done) $display("FAIL t5_no_done: got done pulse want none"); else passes++;
      checks++; if (mw(32'h60) !== 32'h12345678) $display("FAIL t5_mem: got %h want 12345678", mw(32'h60)); else passes++;
      single_txn(0, 1'b0, 32'h60, 32'h0, 3'b010, ok, rd);
      checks++; if (!ok || rd !== 32'h12345678) $display("FAIL t5_idle_after: got ok=%0d rdata=%h want 12345678", ok, rd); else passes++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_single_load();
      test_dual_store();
      test_round_robin();
      test_byte_access();
      test_reset_abort();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
